// File: rtl/i2c_slave_responder.sv
// I2C target with an auto-incrementing register file.
// Open-drain style: sda_o = 0 pulls the line low, 1 releases it; scl is never stretched.
// Bus handshake: there is no valid/ready pair on this block; the only output event is
// wr_strobe_o, a single-cycle qualifier for wr_addr_o/wr_data_o, which hold their last value.
// dbg_state_o exposes the FSM state for external checkers.
module i2c_slave_responder #(
   parameter int unsigned                I2C_ADDR_WIDTH = 7,
   parameter int unsigned                I2C_DATA_WIDTH = 8,
   parameter logic [I2C_ADDR_WIDTH-1:0]  SLAVE_ADDR     = 7'h22,
   parameter int unsigned                NUM_REGS       = 16,
   parameter int unsigned                SYNC_STAGES    = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          scl_i,
   input  logic                          sda_i,
   output logic                          scl_o,
   output logic                          sda_o,
   output logic                          busy_o,
   output logic                          wr_strobe_o,
   output logic [$clog2(NUM_REGS)-1:0]   wr_addr_o,
   output logic [I2C_DATA_WIDTH-1:0]     wr_data_o,
   output logic [2:0]                    dbg_state_o
);

   localparam int unsigned PTR_W = $clog2(NUM_REGS);
   localparam int unsigned DW    = I2C_DATA_WIDTH;
   localparam int unsigned ABITS = I2C_ADDR_WIDTH + 1;
   localparam int unsigned SH_W  = (ABITS > DW) ? ABITS : DW;
   localparam int unsigned CNT_W = $clog2(SH_W + 1);

   localparam logic [CNT_W-1:0] ABITS_C = CNT_W'(ABITS);
   localparam logic [CNT_W-1:0] DW_C    = CNT_W'(DW);
   localparam logic [CNT_W-1:0] DWM1_C  = CNT_W'(DW - 1);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      ADDR_ACK = 3'd2,
      WR_BYTE  = 3'd3,
      WR_ACK   = 3'd4,
      RD_BYTE  = 3'd5,
      RD_ACK   = 3'd6,
      IGNORE   = 3'd7
   } state_t;

   state_t                   state_q, state_d;
   logic [SYNC_STAGES-1:0]   scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0]   sda_sync_q, sda_sync_d;
   logic                     scl_prev_q, scl_prev_d;
   logic                     sda_prev_q, sda_prev_d;
   logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
   logic [SH_W-1:0]          shift_q, shift_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic                     first_q, first_d;
   logic                     sda_q, sda_d;
   logic                     busy_q, busy_d;
   logic                     wr_strobe_q, wr_strobe_d;
   logic [PTR_W-1:0]         wr_addr_q, wr_addr_d;
   logic [DW-1:0]            wr_data_q, wr_data_d;
   logic [DW-1:0]            regs_q [NUM_REGS];
   logic [DW-1:0]            regs_d [NUM_REGS];

   logic                     scl_s, sda_s;
   logic                     scl_rise, scl_fall, start_evt, stop_evt;
   logic [SH_W-1:0]          shift_in;
   logic [DW-1:0]            byte_in;
   logic                     rd_load;

   // Synchronizer chain plus edge-detect stage; START/STOP need scl stable high.
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_s      = scl_sync_q[SYNC_STAGES-1];
      sda_s      = sda_sync_q[SYNC_STAGES-1];
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
      scl_rise   = scl_s & ~scl_prev_q;
      scl_fall   = ~scl_s & scl_prev_q;
      start_evt  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      stop_evt   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
      shift_in   = {shift_q[SH_W-2:0], sda_s};
      byte_in    = shift_in[DW-1:0];
   end

   // Protocol FSM: next state, shifter, pointer, register file and output drive.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      first_d     = first_q;
      sda_d       = sda_q;
      busy_d      = busy_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      regs_d      = regs_q;
      rd_load     = 1'b0;

      if (stop_evt) begin
         state_d   = IDLE;
         sda_d     = 1'b1;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
      end else if (start_evt) begin
         // Plain and repeated START alike; any partial byte is dropped.
         state_d   = ADDR;
         sda_d     = 1'b1;
         busy_d    = 1'b1;
         bit_cnt_d = '0;
         first_d   = 1'b1;
      end else begin
         case (state_q)
            IDLE: ;
            ADDR: begin
               if (scl_rise && bit_cnt_q != ABITS_C) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + ONE_C;
               end else if (scl_fall && bit_cnt_q == ABITS_C) begin
                  if (shift_q[ABITS-1:1] == SLAVE_ADDR) begin
                     sda_d   = 1'b0;
                     state_d = ADDR_ACK;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            ADDR_ACK: begin
               // shift_q[0] still holds the R/W bit of the address byte.
               if (scl_fall) begin
                  sda_d     = 1'b1;
                  bit_cnt_d = '0;
                  if (shift_q[0]) rd_load = 1'b1;
                  else            state_d = WR_BYTE;
               end
            end
            WR_BYTE: begin
               if (scl_rise && bit_cnt_q != DW_C) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + ONE_C;
                  if (bit_cnt_q == DWM1_C) begin
                     if (first_q) begin
                        ptr_d   = byte_in[PTR_W-1:0];
                        first_d = 1'b0;
                     end else begin
                        regs_d[ptr_q] = byte_in;
                        wr_strobe_d   = 1'b1;
                        wr_addr_d     = ptr_q;
                        wr_data_d     = byte_in;
                        ptr_d         = ptr_q + 1'b1;
                     end
                  end
               end else if (scl_fall && bit_cnt_q == DW_C) begin
                  sda_d   = 1'b0;
                  state_d = WR_ACK;
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  sda_d     = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = WR_BYTE;
               end
            end
            RD_BYTE: begin
               // bit_cnt counts bits already placed on the line.
               if (scl_fall) begin
                  if (bit_cnt_q == DW_C) begin
                     sda_d     = 1'b1;
                     bit_cnt_d = '0;
                     state_d   = RD_ACK;
                  end else begin
                     sda_d     = shift_q[DW-2];
                     shift_d   = shift_q << 1;
                     bit_cnt_d = bit_cnt_q + ONE_C;
                  end
               end
            end
            RD_ACK: begin
               // bit_cnt = 1 marks a master ACK seen, waiting for the fall.
               if (scl_rise && bit_cnt_q == '0) begin
                  if (sda_s) state_d = IGNORE;
                  else       bit_cnt_d = ONE_C;
               end else if (scl_fall && bit_cnt_q == ONE_C) begin
                  rd_load = 1'b1;
               end
            end
            IGNORE: ;
            default: state_d = IDLE;
         endcase
      end

      // Start of a read byte: first bit goes out on the same scl fall.
      if (rd_load) begin
         shift_d   = SH_W'(regs_q[ptr_q]);
         sda_d     = regs_q[ptr_q][DW-1];
         bit_cnt_d = ONE_C;
         ptr_d     = ptr_q + 1'b1;
         state_d   = RD_BYTE;
      end
   end

   // State register; reset releases sda and restores reg[i] = i.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         scl_sync_q  <= '1;
         sda_sync_q  <= '1;
         scl_prev_q  <= 1'b1;
         sda_prev_q  <= 1'b1;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         ptr_q       <= '0;
         first_q     <= 1'b0;
         sda_q       <= 1'b1;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= DW'(i);
      end else begin
         state_q     <= state_d;
         scl_sync_q  <= scl_sync_d;
         sda_sync_q  <= sda_sync_d;
         scl_prev_q  <= scl_prev_d;
         sda_prev_q  <= sda_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         first_q     <= first_d;
         sda_q       <= sda_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         regs_q      <= regs_d;
      end
   end

   assign scl_o       = 1'b1;
   assign sda_o       = sda_q;
   assign busy_o      = busy_q;
   assign wr_strobe_o = wr_strobe_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: bit-banged I2C master on a wired-AND bus,
// scoreboard queues for stored bytes and read-back bytes.
module tb_i2c_slave_responder;

   localparam int Q = 8;  // clk cycles per quarter scl period

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ADDR   = 3'd1;
   localparam logic [2:0] S_IGNORE = 3'd7;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       scl_m, sda_m;
   logic       scl_o, sda_o, busy_o, wr_strobe_o;
   logic [3:0] wr_addr_o;
   logic [7:0] wr_data_o;
   logic [2:0] dbg_state;
   logic       scl_bus, sda_bus;

   int         checks = 0;
   int         errors = 0;
   int         low_seen = 0;
   logic       watch_low = 1'b0;

   logic [11:0] exp_q[$];     // {addr, data} of expected stores
   logic [7:0]  rd_exp_q[$];  // expected read-back bytes
   logic [7:0]  rd_obs;
   event        rd_ev;

   assign scl_bus = scl_m & scl_o;
   assign sda_bus = sda_m & sda_o;

   i2c_slave_responder dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .scl_i       (scl_bus),
      .sda_i       (sda_bus),
      .scl_o       (scl_o),
      .sda_o       (sda_o),
      .busy_o      (busy_o),
      .wr_strobe_o (wr_strobe_o),
      .wr_addr_o   (wr_addr_o),
      .wr_data_o   (wr_data_o),
      .dbg_state_o (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every store pulse must match the head of the expected queue.
   always @(negedge clk) begin
      if (wr_strobe_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_store", {20'h0, wr_addr_o, wr_data_o}, 32'hFFFF_FFFF);
         end else begin
            chk("store", {20'h0, wr_addr_o, wr_data_o}, {20'h0, exp_q.pop_front()});
         end
      end
      if (watch_low && !sda_o) low_seen++;
   end

   // Monitor: every byte the master reads back is compared with the expected queue.
   initial begin
      forever begin
         @(rd_ev);
         if (rd_exp_q.size() == 0) chk("unexpected_read", {24'h0, rd_obs}, 32'hFFFF_FFFF);
         else                      chk("read_byte", {24'h0, rd_obs}, {24'h0, rd_exp_q.pop_front()});
      end
   end

   // Driver tasks
   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic clk_bit(input logic b, output logic r);
      sda_m = b;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      r = sda_bus;
      wait_q();
      scl_m = 1'b0;
      wait_q();
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      sda_m = 1'b0;
      wait_q();
      scl_m = 1'b0;
      wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      sda_m = 1'b1;
      wait_q();
      wait_q();
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      logic r;
      for (int i = 7; i > 7 - n; i--) clk_bit(b[i], r);
   endtask

   task automatic wr_byte(input logic [7:0] b, input logic exp_ack);
      logic r;
      send_bits(b, 8);
      clk_bit(1'b1, r);
      chk($sformatf("ack_%02h", b), {31'h0, r}, exp_ack ? 32'h0 : 32'h1);
   endtask

   task automatic rd_byte(input logic [7:0] exp, input logic master_ack);
      logic r;
      logic [7:0] v;
      rd_exp_q.push_back(exp);
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, r);
         v[i] = r;
      end
      clk_bit(~master_ack, r);
      rd_obs = v;
      ->rd_ev;
   endtask

   // Point at ptr with a write, then repeated START into a read.
   task automatic start_read_at(input logic [7:0] ptr);
      i2c_start();
      wr_byte(8'h44, 1'b1);
      wr_byte(ptr, 1'b1);
      i2c_start();
      wr_byte(8'h45, 1'b1);
   endtask

   initial begin
      rst_i = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_sda", {31'h0, sda_o}, 32'h1);
      chk("rst_scl", {31'h0, scl_o}, 32'h1);
      chk("rst_busy", {31'h0, busy_o}, 32'h0);
      chk("rst_strobe", {31'h0, wr_strobe_o}, 32'h0);
      chk("rst_addr", {28'h0, wr_addr_o}, 32'h0);
      chk("rst_data", {24'h0, wr_data_o}, 32'h0);
      chk("rst_state", {29'h0, dbg_state}, {29'h0, S_IDLE});
      rst_i = 1'b0;
      repeat (8) @(negedge clk);

      // Write pointer 3, then AA, BB.
      exp_q.push_back({4'h3, 8'hAA});
      exp_q.push_back({4'h4, 8'hBB});
      i2c_start();
      chk("busy_after_start", {31'h0, busy_o}, 32'h1);
      chk("state_after_start", {29'h0, dbg_state}, {29'h0, S_ADDR});
      wr_byte(8'h44, 1'b1);
      wr_byte(8'h03, 1'b1);
      wr_byte(8'hAA, 1'b1);
      wr_byte(8'hBB, 1'b1);
      i2c_stop();
      chk("busy_after_stop", {31'h0, busy_o}, 32'h0);
      start_read_at(8'h03);
      rd_byte(8'hAA, 1'b1);
      rd_byte(8'hBB, 1'b0);
      i2c_stop();

      // Pointer 5, repeated START, read 05 06 07; pointer then sits at 8.
      start_read_at(8'h05);
      rd_byte(8'h05, 1'b1);
      rd_byte(8'h06, 1'b1);
      rd_byte(8'h07, 1'b0);
      i2c_stop();
      i2c_start();
      wr_byte(8'h45, 1'b1);
      rd_byte(8'h08, 1'b0);
      i2c_stop();

      // Foreign address 0x23: never pulls sda, stays busy until STOP.
      low_seen  = 0;
      watch_low = 1'b1;
      i2c_start();
      wr_byte(8'h46, 1'b0);
      chk("ignore_state", {29'h0, dbg_state}, {29'h0, S_IGNORE});
      wr_byte(8'h5A, 1'b0);
      chk("ignore_busy", {31'h0, busy_o}, 32'h1);
      i2c_stop();
      watch_low = 1'b0;
      chk("ignore_sda_low_cycles", low_seen, 0);
      chk("ignore_busy_after_stop", {31'h0, busy_o}, 32'h0);

      // Pointer 0x0F, bytes 11, 22: wraps to reg 0.
      exp_q.push_back({4'hF, 8'h11});
      exp_q.push_back({4'h0, 8'h22});
      i2c_start();
      wr_byte(8'h44, 1'b1);
      wr_byte(8'h0F, 1'b1);
      wr_byte(8'h11, 1'b1);
      wr_byte(8'h22, 1'b1);
      i2c_stop();
      start_read_at(8'h0F);
      rd_byte(8'h11, 1'b1);
      rd_byte(8'h22, 1'b0);
      i2c_stop();

      // STOP after 4 bits of a data byte: dropped, pointer left at 2.
      i2c_start();
      wr_byte(8'h44, 1'b1);
      wr_byte(8'h02, 1'b1);
      send_bits(8'hA0, 4);
      i2c_stop();
      chk("partial_state", {29'h0, dbg_state}, {29'h0, S_IDLE});
      chk("partial_busy", {31'h0, busy_o}, 32'h0);
      i2c_start();
      wr_byte(8'h45, 1'b1);
      rd_byte(8'h02, 1'b0);
      i2c_stop();

      // Reset while the responder pulls sda low for the address ACK.
      i2c_start();
      send_bits(8'h45, 8);
      sda_m = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      chk("ack_low_before_rst", {31'h0, sda_o}, 32'h0);
      rst_i = 1'b1;
      #1;
      chk("rst_sda_release", {31'h0, sda_o}, 32'h1);
      repeat (4) @(negedge clk);
      chk("midrst_state", {29'h0, dbg_state}, {29'h0, S_IDLE});
      chk("midrst_busy", {31'h0, busy_o}, 32'h0);
      rst_i = 1'b0;
      repeat (8) @(negedge clk);
      start_read_at(8'h03);
      rd_byte(8'h03, 1'b1);
      rd_byte(8'h04, 1'b0);
      i2c_stop();
      start_read_at(8'h0F);
      rd_byte(8'h0F, 1'b1);
      rd_byte(8'h00, 1'b0);
      i2c_stop();

      // Final report
      repeat (8) @(negedge clk);
      chk("stores_outstanding", exp_q.size(), 0);
      chk("reads_outstanding", rd_exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
